// File: rtl/voice_mixer.sv
// N-voice stereo mixer: snapshots all voices on new_frame, accumulates one voice
// per cycle through a shared multiplier, then shifts and saturates L/R/mono outputs.
module voice_mixer #(
    parameter int NUM_VOICES   = 10,
    parameter int SAMPLE_WIDTH = 16,
    parameter int GAIN_WIDTH   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               new_frame,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
    input  logic [NUM_VOICES*GAIN_WIDTH-1:0]   voice_gains,
    input  logic [NUM_VOICES*2-1:0]            voice_pans,
    input  logic [2:0]                         master_shift,
    output logic [SAMPLE_WIDTH-1:0]            sample_out_left,
    output logic [SAMPLE_WIDTH-1:0]            sample_out_right,
    output logic [SAMPLE_WIDTH-1:0]            sample_out,
    output logic                               new_sample_generated,
    output logic                               busy,
    output logic                               overrun
);

    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int ACC_W  = SAMPLE_WIDTH + GAIN_WIDTH + $clog2(NUM_VOICES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - SAMPLE_WIDTH){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W + 2 - SAMPLE_WIDTH){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

    state_t state, state_next;

    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] snap_samples;
    logic [NUM_VOICES*GAIN_WIDTH-1:0]   snap_gains;
    logic [NUM_VOICES*2-1:0]            snap_pans;
    logic [2:0]                         snap_shift;
    logic [IDX_W-1:0]                   index;
    logic signed [ACC_W-1:0]            acc_l;
    logic signed [ACC_W-1:0]            acc_r;

    logic signed [SAMPLE_WIDTH-1:0]            cur_sample;
    logic [GAIN_WIDTH-1:0]                     cur_gain;
    logic [1:0]                                cur_pan;
    logic signed [SAMPLE_WIDTH+GAIN_WIDTH:0]   product;
    logic signed [ACC_W-1:0]                   product_ext;
    logic signed [ACC_W-1:0]                   term;
    logic signed [ACC_W:0]                     sum_lr;
    logic signed [ACC_W:0]                     shifted_l;
    logic signed [ACC_W:0]                     shifted_r;
    logic signed [ACC_W:0]                     shifted_m;
    logic                                      start;

    function automatic logic [SAMPLE_WIDTH-1:0] saturate(input logic signed [ACC_W:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[SAMPLE_WIDTH-1:0];
        end
        if (v < SAT_MIN) begin
            return SAT_MIN[SAMPLE_WIDTH-1:0];
        end
        return v[SAMPLE_WIDTH-1:0];
    endfunction

    // Gain is zero-extended so the single multiplier is a plain signed multiply.
    assign cur_sample  = snap_samples[index*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign cur_gain    = snap_gains[index*GAIN_WIDTH +: GAIN_WIDTH];
    assign cur_pan     = snap_pans[index*2 +: 2];
    assign product     = cur_sample * $signed({1'b0, cur_gain});
    assign product_ext = ACC_W'(product);
    assign term        = product_ext >>> 3;

    assign sum_lr    = (ACC_W + 1)'(acc_l) + (ACC_W + 1)'(acc_r);
    assign shifted_l = (ACC_W + 1)'(acc_l >>> snap_shift);
    assign shifted_r = (ACC_W + 1)'(acc_r >>> snap_shift);
    assign shifted_m = sum_lr >>> ({1'b0, snap_shift} + 4'd1);

    // The pulse cycle after SAT still counts as busy so a frame arriving with it is dropped.
    assign busy  = (state != IDLE) || new_sample_generated;
    assign start = new_frame && !busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (index == LAST_IDX) state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_samples         <= '0;
            snap_gains           <= '0;
            snap_pans            <= '0;
            snap_shift           <= '0;
            index                <= '0;
            acc_l                <= '0;
            acc_r                <= '0;
            sample_out_left      <= '0;
            sample_out_right     <= '0;
            sample_out           <= '0;
            new_sample_generated <= 1'b0;
            overrun              <= 1'b0;
        end else begin
            new_sample_generated <= 1'b0;
            overrun              <= new_frame && busy;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        snap_samples <= voice_samples;
                        snap_gains   <= voice_gains;
                        snap_pans    <= voice_pans;
                        snap_shift   <= master_shift;
                        index        <= '0;
                        acc_l        <= '0;
                        acc_r        <= '0;
                    end
                end
                ACCUM: begin
                    case (cur_pan)
                        2'b00: begin
                            acc_l <= acc_l + term;
                            acc_r <= acc_r + term;
                        end
                        2'b01:   acc_l <= acc_l + term;
                        2'b10:   acc_r <= acc_r + term;
                        default: ;
                    endcase
                    index <= index + 1'b1;
                end
                SAT: begin
                    sample_out_left      <= saturate(shifted_l);
                    sample_out_right     <= saturate(shifted_r);
                    sample_out           <= saturate(shifted_m);
                    new_sample_generated <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Randomized scoreboard bench for voice_mixer: expected mixes come from an
// arithmetic reference model and are checked by an independent output monitor.
module tb_voice_mixer;

    localparam int NV = 10;
    localparam int SW = 16;
    localparam int GW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              new_frame = 1'b0;
    logic [NV*SW-1:0]  voice_samples = '0;
    logic [NV*GW-1:0]  voice_gains = '0;
    logic [NV*2-1:0]   voice_pans = '0;
    logic [2:0]        master_shift = '0;
    logic [SW-1:0]     sample_out_left;
    logic [SW-1:0]     sample_out_right;
    logic [SW-1:0]     sample_out;
    logic              new_sample_generated;
    logic              busy;
    logic              overrun;

    typedef struct {
        int l;
        int r;
        int m;
        int at;
    } exp_t;

    exp_t sb[$];
    int   stim_s[NV];
    int   stim_g[NV];
    int   stim_p[NV];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    voice_mixer #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .GAIN_WIDTH(GW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .new_frame            (new_frame),
        .voice_samples        (voice_samples),
        .voice_gains          (voice_gains),
        .voice_pans           (voice_pans),
        .master_shift         (master_shift),
        .sample_out_left      (sample_out_left),
        .sample_out_right     (sample_out_right),
        .sample_out           (sample_out),
        .new_sample_generated (new_sample_generated),
        .busy                 (busy),
        .overrun              (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic longint floorDiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Mix as plain arithmetic: floor(sample*gain/8) routed by pan, then floor-scaled and clamped.
    function automatic exp_t model(input int sh, input int at);
        exp_t   e;
        longint al = 0;
        longint ar = 0;
        longint t;
        for (int i = 0; i < NV; i++) begin
            t = floorDiv(longint'(stim_s[i]) * longint'(stim_g[i]), 8);
            if (stim_p[i] == 0 || stim_p[i] == 1) al += t;
            if (stim_p[i] == 0 || stim_p[i] == 2) ar += t;
        end
        e.l  = clamp16(floorDiv(al, longint'(1) << sh));
        e.r  = clamp16(floorDiv(ar, longint'(1) << sh));
        e.m  = clamp16(floorDiv(al + ar, longint'(1) << (sh + 1)));
        e.at = at;
        return e;
    endfunction

    task automatic clearVoices();
        for (int i = 0; i < NV; i++) begin
            stim_s[i] = 0;
            stim_g[i] = 0;
            stim_p[i] = 3;
        end
    endtask

    task automatic setVoice(input int i, input int s, input int g, input int p);
        stim_s[i] = s;
        stim_g[i] = g;
        stim_p[i] = p;
    endtask

    task automatic driveInputs(input int sh);
        for (int i = 0; i < NV; i++) begin
            voice_samples[i*SW +: SW] = SW'(stim_s[i]);
            voice_gains[i*GW +: GW]   = GW'(stim_g[i]);
            voice_pans[i*2 +: 2]      = 2'(stim_p[i]);
        end
        master_shift = 3'(sh);
    endtask

    // Issues one frame, records the expected result, then scrambles the inputs.
    task automatic applyStimulus(input int sh, output int c);
        @(negedge clk);
        driveInputs(sh);
        c = cyc;
        new_frame = 1'b1;
        sb.push_back(model(sh, cyc + 12));
        @(negedge clk);
        new_frame = 1'b0;
        for (int i = 0; i < NV; i++) begin
            voice_samples[i*SW +: SW] = SW'($urandom);
            voice_gains[i*GW +: GW]   = GW'($urandom);
            voice_pans[i*2 +: 2]      = 2'($urandom);
        end
        master_shift = 3'($urandom);
    endtask

    task automatic waitDone();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (new_sample_generated) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("left", int'($signed(sample_out_left)), e.l);
                    checkOutput("right", int'($signed(sample_out_right)), e.r);
                    checkOutput("mono", int'($signed(sample_out)), e.m);
                    checkOutput("latency", cyc, e.at);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int sh;
        clearVoices();
        driveInputs(0);
        repeat (3) @(negedge clk);
        checkOutput("reset_left", int'(sample_out_left), 0);
        checkOutput("reset_right", int'(sample_out_right), 0);
        checkOutput("reset_mono", int'(sample_out), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_pulse", int'(new_sample_generated), 0);
        checkOutput("reset_overrun", int'(overrun), 0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] single centre voice");
        clearVoices();
        setVoice(0, 1000, 8, 0);
        applyStimulus(0, c);
        for (int k = 1; k <= 12; k++) begin
            checkOutput($sformatf("busy_cycle%0d", k), int'(busy), 1);
            @(negedge clk);
        end
        checkOutput("busy_after", int'(busy), 0);
        waitDone();
        checkOutput("case1_mono", int'($signed(sample_out)), 1000);

        $display("[TB] left/right pans");
        clearVoices();
        setVoice(1, 1200, 8, 1);
        setVoice(2, -400, 8, 2);
        applyStimulus(0, c);
        waitDone();
        checkOutput("case2_mono", int'($signed(sample_out)), 400);

        $display("[TB] gain rounding");
        clearVoices();
        setVoice(0, 1000, 4, 0);
        applyStimulus(0, c);
        waitDone();
        checkOutput("case3a_left", int'($signed(sample_out_left)), 500);
        clearVoices();
        setVoice(0, -1001, 3, 0);
        applyStimulus(0, c);
        waitDone();
        checkOutput("case3b_left", int'($signed(sample_out_left)), -376);

        $display("[TB] saturation");
        for (int i = 0; i < NV; i++) setVoice(i, 30000, 15, 0);
        applyStimulus(0, c);
        waitDone();
        checkOutput("sat_pos_left", int'($signed(sample_out_left)), 32767);
        for (int i = 0; i < NV; i++) setVoice(i, -32768, 15, 0);
        applyStimulus(0, c);
        waitDone();
        checkOutput("sat_neg_mono", int'($signed(sample_out)), -32768);
        for (int i = 0; i < NV; i++) setVoice(i, 30000, 15, 0);
        applyStimulus(7, c);
        waitDone();

        $display("[TB] overrun");
        clearVoices();
        setVoice(3, 2000, 8, 0);
        applyStimulus(0, c);
        repeat (4) @(negedge clk);
        clearVoices();
        setVoice(3, -5000, 15, 1);
        driveInputs(2);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        checkOutput("overrun_pulse", int'(overrun), 1);
        @(negedge clk);
        checkOutput("overrun_single", int'(overrun), 0);
        while (cyc < c + 12) @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        checkOutput("overrun_at_pulse", int'(overrun), 1);
        waitDone();
        repeat (15) @(negedge clk);
        checkOutput("overrun_result_held", int'($signed(sample_out_left)), 2000);
        clearVoices();
        setVoice(4, 700, 8, 2);
        applyStimulus(0, c);
        waitDone();

        $display("[TB] reset mid-accumulation");
        clearVoices();
        setVoice(0, 1000, 8, 0);
        applyStimulus(0, c);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_right", int'(sample_out_right), 0);
        checkOutput("abort_mono", int'(sample_out), 0);
        repeat (15) @(negedge clk);
        applyStimulus(0, c);
        waitDone();
        checkOutput("after_abort_left", int'($signed(sample_out_left)), 1000);

        $display("[TB] random frames");
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NV; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    stim_s[i] = ($urandom_range(0, 1) == 0) ? 32767 : -32768;
                end else begin
                    stim_s[i] = int'($signed(16'($urandom)));
                end
                stim_g[i] = $urandom_range(0, 15);
                stim_p[i] = $urandom_range(0, 3);
            end
            sh = $urandom_range(0, 7);
            applyStimulus(sh, c);
            waitDone();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
